// File: rtl/write_resp_router.sv
// rtl/write_resp_router.sv - routes slave write responses back to the owning master in AW order
module write_resp_router #(
  parameter int OUTSTANDING_DEPTH = 4,
  parameter int CNT_W             = $clog2(OUTSTANDING_DEPTH + 1)
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             AW_Handshake,
  input  logic             AW_Master_Sel,
  output logic             AW_Block,
  input  logic             M_AXI_bvalid,
  input  logic [1:0]       M_AXI_bresp,
  output logic             M_AXI_bready,
  output logic             S00_AXI_bvalid,
  output logic [1:0]       S00_AXI_bresp,
  input  logic             S00_AXI_bready,
  output logic             S01_AXI_bvalid,
  output logic [1:0]       S01_AXI_bresp,
  input  logic             S01_AXI_bready,
  output logic [CNT_W-1:0] Outstanding_Count,
  output logic             Err_Unexpected_B,
  output logic             Err_Overflow
);

  localparam int PW = $clog2(OUTSTANDING_DEPTH);

  logic [OUTSTANDING_DEPTH-1:0] ids_q;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         err_unexp_q, err_unexp_d;
  logic                         err_ovf_q, err_ovf_d;
  logic                         not_empty, full, head, push, pop;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(OUTSTANDING_DEPTH));
  assign head      = ids_q[rd_ptr_q];

  assign M_AXI_bready   = not_empty & (head ? S01_AXI_bready : S00_AXI_bready);
  assign S00_AXI_bvalid = M_AXI_bvalid & not_empty & ~head;
  assign S01_AXI_bvalid = M_AXI_bvalid & not_empty & head;
  assign S00_AXI_bresp  = M_AXI_bresp;
  assign S01_AXI_bresp  = M_AXI_bresp;

  // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
  assign pop  = M_AXI_bvalid & M_AXI_bready;
  assign push = AW_Handshake & (~full | pop);

  assign AW_Block          = full;
  assign Outstanding_Count = count_q;
  assign Err_Unexpected_B  = err_unexp_q;
  assign Err_Overflow      = err_ovf_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_unexp_d = err_unexp_q;
    err_ovf_d   = err_ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (M_AXI_bvalid && !not_empty)  err_unexp_d = 1'b1;
    if (AW_Handshake && !push)       err_ovf_d   = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_unexp_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_unexp_q <= err_unexp_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // ID storage needs no reset: entries are only read while count is nonzero.
  always_ff @(posedge ACLK) begin
    if (push) ids_q[wr_ptr_q] <= AW_Master_Sel;
  end

endmodule
